demux_two_32bit_stream: RTL and testbench
=========================================

Name: demux_two_32bit_stream

Overview:
- 1-to-2 stream demultiplexer: the steering counterpart of the 2:1 32-bit select mux used across the datapath.
- Accepts one 32-bit word per cycle on a valid/ready input and routes it to sink 1 (control=0) or sink 2 (control=1).
- Each sink has its own small FIFO, so a stalled sink does not block traffic to the other sink once steering moves away from it.
- Each sink has a 16-bit delivered-word counter.

Parameters:
- WIDTH, 32: data width of input and both outputs.
- DEPTH, 2: entries per output FIFO; must be a power of two and at least 2.
- CNT_W, 16: width of each delivered-word counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  word to steer.
- in_valid  input  1  in_data is valid.
- control  input  1  destination select: 0 selects sink 1, 1 selects sink 2. Sampled together with in_data.
- in_ready  output  1  block can accept the word this cycle.
- out1_data  output  WIDTH  head word of FIFO 1.
- out1_valid  output  1  FIFO 1 is not empty.
- out1_ready  input  1  sink 1 consumes the head word.
- out2_data  output  WIDTH  head word of FIFO 2.
- out2_valid  output  1  FIFO 2 is not empty.
- out2_ready  input  1  sink 2 consumes the head word.
- cnt1  output  CNT_W  number of words delivered on output 1.
- cnt2  output  CNT_W  number of words delivered on output 2.

Behaviour:
- Clock and reset: one clock, clk. Synchronous active-high reset on reset.
- Reset values: out1_valid=0, out2_valid=0, out1_data=0, out2_data=0, cnt1=0, cnt2=0. in_ready=0 while reset is high; in_ready=1 in the first cycle after reset deasserts.
- Reset mid-operation: all FIFO contents are discarded and no partial transfer survives.
- Input handshake:
  - Transfer occurs when in_valid && in_ready.
  - in_ready = (control ? !full2 : !full1). It depends only on control and registered FIFO state, never on out*_ready; there is no combinational ready path.
  - On a transfer, in_data is pushed into FIFO1 if control=0, else into FIFO2. The non-selected FIFO is untouched.
  - The sender holds in_data and control stable while in_valid && !in_ready. The block does not check this. If control changes during a stall, the new value applies in the same cycle.
- Latency: a word accepted at edge N appears on outX_data with outX_valid=1 after edge N, provided FIFO X was empty. This is 1-cycle latency; there is no bypass in the same cycle.
- Output handshake:
  - Pop when outX_valid && outX_ready.
  - outX_valid is held until the pop.
  - outX_data is stable while outX_valid=1 and not popped.
  - outX_data = 0 whenever outX_valid = 0.
- Ordering: FIFO order is preserved per output. There is no ordering guarantee between output 1 and output 2.
- FIFO boundary conditions:
  - full: count == DEPTH. empty: count == 0.
  - Read and write pointers wrap modulo DEPTH.
  - Push and pop in the same cycle with count between 1 and DEPTH-1: count unchanged and both operations take effect.
  - Push and pop in the same cycle with count == 0: impossible, because no bypass exists.
  - FIFO full plus pop: in_ready was 0 that cycle, so there is no push. in_ready for that destination becomes 1 the next cycle.
  - outX_ready asserted while empty: no effect and no counter change.
- Counters:
  - cntX increments by 1 on each pop of output X.
  - Wraps from 2^CNT_W-1 to 0 with no saturation and no flag.
  - Pops on both outputs in the same cycle increment both counters.
- Throughput: 1 word/cycle sustained to a single output whose ready is held high.
- No internal state machine beyond the FIFO pointers and counts. No error outputs.

Test Plan:
- Reset, then stream 0x11111111, 0x22222222, 0x33333333 with control=0 and out1_ready=1 -> out1 shows each word 1 cycle after its acceptance; out2_valid stays 0; cnt1=3, cnt2=0.
- Alternate control 0,1,0,1 with words A0..A3, both readies high -> out1 receives A0, A2 and out2 receives A1, A3 in order; cnt1=2, cnt2=2; in_ready=1 throughout.
- out1_ready=0, push 0xDEAD0001 and 0xDEAD0002 with control=0 -> in_ready=0 with control=0. Then switch control=1 and push 0xBEEF0001 -> accepted, appears on out2. Then raise out1_ready -> 0xDEAD0001 then 0xDEAD0002 are delivered, and in_ready(control=0) returns to 1 one cycle after the first pop.
- FIFO1 holds one entry, out1_ready=1, and a control=0 push in the same cycle -> count stays 1 and the new word is the next head; no drop and no duplicate.
- Preload cnt1 to 0xFFFF through 65535 pops, then one more pop -> cnt1=0x0000.
- Assert reset with both FIFOs full and the counters nonzero -> the next cycle shows all valids=0, data=0, counters=0. The first cycle after reset deasserts shows in_ready=1. Old words never appear.

Source files
------------

// File: rtl/demux_two_32bit_stream.sv
// 1-to-2 stream demultiplexer: each input word is steered by control into one of
// two small output FIFOs, each with its own wrapping delivered-word counter.
module demux_two_32bit_stream #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             control,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  initial begin
    assert (DEPTH >= 2 && (DEPTH & (DEPTH - 1)) == 0)
      else $fatal(1, "DEPTH must be a power of two and at least 2");
  end

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic [CNT_W-1:0] cnt_q;
    logic             full;
    logic             empty;
    logic             sel_ready;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign sel_ready = (g == 0) ? out1_ready : out2_ready;
    assign push      = in_valid && in_ready && (control == (g != 0));
    assign pop       = !empty && sel_ready;
    // Data is masked while empty so stale entries never leak after a reset.
    assign head      = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
      if (push) begin
        mem[wptr] <= in_data;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
        cnt_q <= '0;
      end else begin
        if (push) begin
          wptr <= wptr + 1'b1;
        end
        if (pop) begin
          rptr  <= rptr + 1'b1;
          cnt_q <= cnt_q + 1'b1;
        end
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Ready looks only at the selected FIFO's registered fill level.
  assign in_ready   = !reset && (control ? !g_ch[1].full : !g_ch[0].full);

  assign out1_valid = !g_ch[0].empty;
  assign out1_data  = g_ch[0].head;
  assign cnt1       = g_ch[0].cnt_q;

  assign out2_valid = !g_ch[1].empty;
  assign out2_data  = g_ch[1].head;
  assign cnt2       = g_ch[1].cnt_q;

endmodule

// File: tb/tb_demux_two_32bit_stream.sv
// Bench for demux_two_32bit_stream: directed plan steps plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_demux_two_32bit_stream;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             control;
  logic             in_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out2_data;
  logic             out2_valid;
  logic             out2_ready;
  logic [CNT_W-1:0] cnt1;
  logic [CNT_W-1:0] cnt2;

  demux_two_32bit_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .control(control), .in_ready(in_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out2_data(out2_data), .out2_valid(out2_valid), .out2_ready(out2_ready),
    .cnt1(cnt1), .cnt2(cnt2)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] q1[$];
  logic [WIDTH-1:0] q2[$];
  int unsigned      m_cnt1;
  int unsigned      m_cnt2;
  int               ncmp = 0;
  int               nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic c, input logic [WIDTH-1:0] d,
                       input logic r1, input logic r2);
    in_valid   = v;
    control    = c;
    in_data    = d;
    out1_ready = r1;
    out2_ready = r2;
  endtask

  // Compare DUT against the model, then advance the model across one clock edge.
  task automatic step();
    logic exp_rdy;
    @(negedge clk);
    if (reset) exp_rdy = 1'b0;
    else       exp_rdy = control ? (q2.size() < DEPTH) : (q1.size() < DEPTH);
    chk("in_ready",   in_ready,   exp_rdy);
    chk("out1_valid", out1_valid, q1.size() > 0);
    chk("out1_data",  out1_data,  q1.size() > 0 ? q1[0] : 32'd0);
    chk("out2_valid", out2_valid, q2.size() > 0);
    chk("out2_data",  out2_data,  q2.size() > 0 ? q2[0] : 32'd0);
    chk("cnt1",       cnt1,       m_cnt1);
    chk("cnt2",       cnt2,       m_cnt2);
    @(posedge clk);
    if (reset) begin
      q1.delete();
      q2.delete();
      m_cnt1 = 0;
      m_cnt2 = 0;
    end else begin
      if (q1.size() > 0 && out1_ready) begin
        void'(q1.pop_front());
        m_cnt1 = (m_cnt1 + 1) % 65536;
      end
      if (q2.size() > 0 && out2_ready) begin
        void'(q2.pop_front());
        m_cnt2 = (m_cnt2 + 1) % 65536;
      end
      if (in_valid && exp_rdy) begin
        if (control) q2.push_back(in_data);
        else         q1.push_back(in_data);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    m_cnt1 = 0;
    m_cnt2 = 0;
    reset  = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    step();
    reset = 1'b0;

    // Single-destination stream.
    drive(1'b1, 1'b0, 32'h1111_1111, 1'b1, 1'b1); step();
    drive(1'b1, 1'b0, 32'h2222_2222, 1'b1, 1'b1); step();
    drive(1'b1, 1'b0, 32'h3333_3333, 1'b1, 1'b1); step();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);            step();
    chk("t1_cnt1", cnt1, 16'd3);
    chk("t1_cnt2", cnt2, 16'd0);

    // Alternating steering.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i[0], 32'hA000_0000 + i, 1'b1, 1'b1);
      step();
    end
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1); step();
    chk("t2_cnt1", cnt1, 16'd2);
    chk("t2_cnt2", cnt2, 16'd2);

    // Stalled sink 1 does not block sink 2.
    drive(1'b1, 1'b0, 32'hDEAD_0001, 1'b0, 1'b1); step();
    drive(1'b1, 1'b0, 32'hDEAD_0002, 1'b0, 1'b1); step();
    drive(1'b1, 1'b0, 32'hDEAD_0003, 1'b0, 1'b1); step();
    chk("t3_stall_ready", in_ready, 1'b0);
    drive(1'b1, 1'b1, 32'hBEEF_0001, 1'b0, 1'b1); step();
    chk("t3_out2_data", out2_data, 32'hBEEF_0001);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1); step();
    chk("t3_ready_back", in_ready, 1'b1);
    step();
    step();

    // Push and pop in the same cycle with one entry held.
    drive(1'b1, 1'b0, 32'h0000_0A0A, 1'b0, 1'b0); step();
    drive(1'b1, 1'b0, 32'h0000_0B0B, 1'b1, 1'b0); step();
    chk("t4_head", out1_data, 32'h0000_0B0B);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0); step();

    // Reset with both FIFOs full and counters nonzero.
    drive(1'b1, 1'b1, 32'h5555_0001, 1'b0, 1'b0); step();
    drive(1'b1, 1'b1, 32'h5555_0002, 1'b0, 1'b0); step();
    drive(1'b1, 1'b0, 32'h6666_0002, 1'b0, 1'b0); step();
    reset = 1'b1;
    drive(1'b1, 1'b0, 32'h7777_7777, 1'b1, 1'b1); step();
    chk("t6_cnt1", cnt1, 16'd0);
    chk("t6_valid1", out1_valid, 1'b0);
    reset = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1); step();
    chk("t6_ready_after", in_ready, 1'b1);
    step();

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
      step();
    end
    reset = 1'b0;

    // Counter wrap on output 1.
    do_reset();
    drive(1'b1, 1'b0, 32'hC0DE_0000, 1'b1, 1'b0);
    for (int i = 0; i < 65535; i++) begin
      in_data = 32'hC0DE_0000 + i;
      step();
    end
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0); step();
    chk("t5_cnt1_full", cnt1, 16'hFFFF);
    drive(1'b1, 1'b0, 32'hC0DE_FFFF, 1'b1, 1'b0); step();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0); step();
    chk("t5_cnt1_wrap", cnt1, 16'h0000);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
